keypad_emulator: RTL and testbench

- Behavioural-in-silicon model of the 4x4 matrix keypad: the passive end of the column-scan / row-sense interface.
- Host commands press or release one key; the block drives `filas_raw` from the scanned `columnas` exactly as the physical switch matrix would, including optional contact bounce.
- Sits in place of the real keypad for on-board self-test and simulation of the scanner/debouncer path.

---
 rtl/keypad_pkg.sv | 29 ++
 rtl/keypad_bounce_gen.sv | 83 ++++++++
 rtl/keypad_emulator.sv | 174 +++++++++++++++++
 tb/tb_keypad_emulator.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad emulator: state encoding,
// packed key code and row/column accessors.
package keypad_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;

  typedef enum logic [1:0] {
    KP_IDLE_UP   = 2'd0,
    KP_BOUNCE_DN = 2'd1,
    KP_HELD      = 2'd2,
    KP_BOUNCE_UP = 2'd3
  } kp_state_e;

  // Key code layout on the command bus: [3:2] row, [1:0] column.
  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_code_t;

  function automatic logic [1:0] key_row(input key_code_t k);
    return k.row;
  endfunction

  function automatic logic [1:0] key_col(input key_code_t k);
    return k.col;
  endfunction

endpackage

// File: rtl/keypad_bounce_gen.sv
// Contact bounce generator: after a start pulse the contact goes to the target,
// then inverts every BOUNCE_PERIOD cycles BOUNCE_TOGGLES times before done.
module keypad_bounce_gen
  import keypad_pkg::*;
#(
  parameter int BOUNCE_PERIOD  = 4,
  parameter int BOUNCE_TOGGLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic target_i,
  output logic contact_o,
  output logic done_o
);

  localparam int PW = (BOUNCE_PERIOD < 2) ? 1 : $clog2(BOUNCE_PERIOD + 1);
  localparam int TW = (BOUNCE_TOGGLES < 2) ? 1 : $clog2(BOUNCE_TOGGLES + 1);
  localparam logic [PW-1:0] PER_MAX = PW'(BOUNCE_PERIOD);
  localparam logic [TW-1:0] TOG_MAX = TW'(BOUNCE_TOGGLES);

  logic          active_q, active_d;
  logic          first_q, first_d;
  logic          target_q, target_d;
  logic          contact_q, contact_d;
  logic [PW-1:0] per_q, per_d;
  logic [TW-1:0] tog_q, tog_d;

  assign contact_o = contact_q;
  assign done_o    = active_q && !first_q && (per_q == PER_MAX) && (tog_q == TOG_MAX);

  always_comb begin
    active_d  = active_q;
    first_d   = first_q;
    target_d  = target_q;
    contact_d = contact_q;
    per_d     = per_q;
    tog_d     = tog_q;
    if (start_i) begin
      active_d = 1'b1;
      first_d  = 1'b1;
      target_d = target_i;
      per_d    = '0;
      tog_d    = '0;
    end else if (active_q) begin
      // First active cycle lands on the target; the level counter then runs 1..PERIOD.
      if (first_q) begin
        contact_d = target_q;
        first_d   = 1'b0;
        per_d     = PW'(1);
      end else if (per_q == PER_MAX) begin
        if (tog_q == TOG_MAX) begin
          active_d = 1'b0;
        end else begin
          contact_d = ~contact_q;
          tog_d     = tog_q + TW'(1);
          per_d     = PW'(1);
        end
      end else begin
        per_d = per_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q  <= 1'b0;
      first_q   <= 1'b0;
      target_q  <= 1'b0;
      contact_q <= 1'b0;
      per_q     <= '0;
      tog_q     <= '0;
    end else begin
      active_q  <= active_d;
      first_q   <= first_d;
      target_q  <= target_d;
      contact_q <= contact_d;
      per_q     <= per_d;
      tog_q     <= tog_d;
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// Passive 4x4 keypad model driving row sense from the scanned columns.
// Define KEYPAD_EMU_BOUNCE_EN to enable contact bounce on press/release.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int BOUNCE_PERIOD  = 4,
  parameter int BOUNCE_TOGGLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_press,
  input  logic [3:0] cmd_key,
  input  logic [3:0] columnas,
  output logic [3:0] filas_raw,
  output logic       key_down,
  output logic       cmd_err,
  output logic [7:0] press_count,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] IDLE_UP   = KP_IDLE_UP;
  localparam logic [1:0] BOUNCE_DN = KP_BOUNCE_DN;
  localparam logic [1:0] HELD      = KP_HELD;
  localparam logic [1:0] BOUNCE_UP = KP_BOUNCE_UP;

  // Reject illegal bounce shapes at elaboration.
  if (BOUNCE_PERIOD < 1 || (BOUNCE_TOGGLES % 2) != 0) begin : g_bad_bounce_cfg
    $error("keypad_emulator: BOUNCE_PERIOD must be >=1 and BOUNCE_TOGGLES even");
  end

  // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready
  // are both high; cmd_ready depends only on state, never on cmd_valid.
  logic [1:0] state_q, state_d;
  key_code_t  key_q, key_d;
  logic       key_down_q, key_down_d;
  logic [7:0] count_q, count_d;
  logic       err_q, err_d;
  logic       xfer;
  logic       bnc_start;
  logic       bnc_target;
  logic       bnc_done;
  logic       contact;

  assign cmd_ready   = (state_q == IDLE_UP) || (state_q == HELD);
  assign xfer        = cmd_valid && cmd_ready;
  assign key_down    = key_down_q;
  assign cmd_err     = err_q;
  assign press_count = count_q;
  assign dbg_state   = state_q;

`ifdef KEYPAD_EMU_BOUNCE_EN
  keypad_bounce_gen #(
    .BOUNCE_PERIOD (BOUNCE_PERIOD),
    .BOUNCE_TOGGLES(BOUNCE_TOGGLES)
  ) u_bounce (
    .clk      (clk),
    .reset    (reset),
    .start_i  (bnc_start),
    .target_i (bnc_target),
    .contact_o(contact),
    .done_o   (bnc_done)
  );
`else
  // Clean contact: target on the edge after acceptance, done one edge later.
  logic [1:0] stage_q, stage_d;
  logic       tgt_q, tgt_d;
  logic       contact_q, contact_d;

  assign contact  = contact_q;
  assign bnc_done = (stage_q == 2'd2);

  always_comb begin
    stage_d   = stage_q;
    tgt_d     = tgt_q;
    contact_d = contact_q;
    if (bnc_start) begin
      stage_d = 2'd1;
      tgt_d   = bnc_target;
    end else if (stage_q == 2'd1) begin
      contact_d = tgt_q;
      stage_d   = 2'd2;
    end else if (stage_q == 2'd2) begin
      stage_d = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q   <= 2'd0;
      tgt_q     <= 1'b0;
      contact_q <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      tgt_q     <= tgt_d;
      contact_q <= contact_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    key_down_d = key_down_q;
    count_d    = count_q;
    err_d      = 1'b0;
    bnc_start  = 1'b0;
    bnc_target = 1'b0;
    case (state_q)
      IDLE_UP: begin
        if (xfer) begin
          if (cmd_press) begin
            key_d      = key_code_t'(cmd_key);
            state_d    = BOUNCE_DN;
            bnc_start  = 1'b1;
            bnc_target = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BOUNCE_DN: begin
        if (bnc_done) begin
          state_d    = HELD;
          key_down_d = 1'b1;
          count_d    = count_q + 8'd1;
        end
      end
      HELD: begin
        if (xfer) begin
          if (cmd_press) begin
            err_d = 1'b1;
          end else begin
            state_d   = BOUNCE_UP;
            bnc_start = 1'b1;
          end
        end
      end
      BOUNCE_UP: begin
        if (bnc_done) begin
          state_d    = IDLE_UP;
          key_down_d = 1'b0;
        end
      end
      default: state_d = IDLE_UP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE_UP;
      key_q      <= '0;
      key_down_q <= 1'b0;
      count_q    <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      key_down_q <= key_down_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  // Switch matrix: the closed contact shorts the latched column onto its row.
  always_comb begin
    filas_raw = 4'hF;
    if (contact && !columnas[key_col(key_q)]) begin
      filas_raw[key_row(key_q)] = 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed self-checking bench for keypad_emulator; expectations follow the
// bounce shape selected by KEYPAD_EMU_BOUNCE_EN.
module tb_keypad_emulator;

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BP = 4;
  localparam int BT = 4;
`else
  localparam int BP = 1;
  localparam int BT = 0;
`endif
  localparam int BLEN = BP * (BT + 1);
  localparam logic [3:0] ROW1_LOW = 4'b1101;
  localparam logic [3:0] ALL_HIGH = 4'hF;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_press;
  logic [3:0] cmd_key;
  logic [3:0] columnas;
  logic [3:0] filas_raw;
  logic       key_down;
  logic       cmd_err;
  logic [7:0] press_count;
  logic [1:0] dbg_state;

  int tests = 0;
  int fails = 0;

  keypad_emulator dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_press  (cmd_press),
    .cmd_key    (cmd_key),
    .columnas   (columnas),
    .filas_raw  (filas_raw),
    .key_down   (key_down),
    .cmd_err    (cmd_err),
    .press_count(press_count),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic wait_ready();
    for (int i = 0; i < 400 && !cmd_ready; i++) begin
      @(posedge clk); #1;
    end
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL wait_ready: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  // Returns #1 after the accepting edge.
  task automatic send_cmd(input logic press, input logic [3:0] key);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_press = press;
    cmd_key   = key;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_press = 1'b0; cmd_key = 4'h0;
    columnas = 4'b1110;
    #12;
    tests++; if (filas_raw !== ALL_HIGH) begin fails++; $display("FAIL reset_filas: got %h want %h", filas_raw, ALL_HIGH); end
    tests++; if (key_down !== 1'b0) begin fails++; $display("FAIL reset_key_down: got %b want 0", key_down); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    tests++; if (press_count !== 8'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", press_count); end
    tests++; if (cmd_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", cmd_err); end
    reset = 1'b0;
    @(posedge clk); #1;
    tests++; if (filas_raw !== ALL_HIGH) begin fails++; $display("FAIL post_reset_filas: got %h want %h", filas_raw, ALL_HIGH); end
  endtask

  task automatic test_press();
    logic [3:0] exp_f;
    columnas = 4'b1011;
    send_cmd(1'b1, 4'b0110);
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL press_ready_e0: got %b want 0", cmd_ready); end
    tests++; if (filas_raw !== ALL_HIGH) begin fails++; $display("FAIL press_filas_e0: got %h want %h", filas_raw, ALL_HIGH); end
    tests++; if (dbg_state !== 2'd1) begin fails++; $display("FAIL press_state_e0: got %0d want 1", dbg_state); end
    for (int k = 1; k <= BLEN; k++) begin
      @(posedge clk); #1;
      exp_f = (((k - 1) / BP) % 2 == 0) ? ROW1_LOW : ALL_HIGH;
      tests++; if (filas_raw !== exp_f) begin fails++; $display("FAIL press_bounce_filas k=%0d: got %h want %h", k, filas_raw, exp_f); end
      tests++; if (key_down !== 1'b0 || cmd_ready !== 1'b0) begin fails++; $display("FAIL press_bounce_flags k=%0d: key_down=%b ready=%b want 0/0", k, key_down, cmd_ready); end
      tests++; if (press_count !== 8'd0) begin fails++; $display("FAIL press_bounce_count k=%0d: got %0d want 0", k, press_count); end
    end
    @(posedge clk); #1;
    tests++; if (key_down !== 1'b1) begin fails++; $display("FAIL press_key_down: got %b want 1", key_down); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL press_ready: got %b want 1", cmd_ready); end
    tests++; if (filas_raw !== ROW1_LOW) begin fails++; $display("FAIL press_filas: got %h want %h", filas_raw, ROW1_LOW); end
    tests++; if (press_count !== 8'd1) begin fails++; $display("FAIL press_count: got %0d want 1", press_count); end
    tests++; if (dbg_state !== 2'd2) begin fails++; $display("FAIL press_state: got %0d want 2", dbg_state); end
  endtask

  task automatic test_columns();
    columnas = 4'b1101; #1;
    tests++; if (filas_raw !== ALL_HIGH) begin fails++; $display("FAIL col_other: got %h want %h", filas_raw, ALL_HIGH); end
    columnas = 4'b0000; #1;
    tests++; if (filas_raw !== ROW1_LOW) begin fails++; $display("FAIL col_all_low: got %h want %h", filas_raw, ROW1_LOW); end
    columnas = 4'b1111; #1;
    tests++; if (filas_raw !== ALL_HIGH) begin fails++; $display("FAIL col_none: got %h want %h", filas_raw, ALL_HIGH); end
    columnas = 4'b1011; #1;
    tests++; if (filas_raw !== ROW1_LOW) begin fails++; $display("FAIL col_latched: got %h want %h", filas_raw, ROW1_LOW); end
  endtask

  task automatic test_held_press_err();
    send_cmd(1'b1, 4'b0001);
    tests++; if (cmd_err !== 1'b1) begin fails++; $display("FAIL held_err_pulse: got %b want 1", cmd_err); end
    tests++; if (dbg_state !== 2'd2) begin fails++; $display("FAIL held_err_state: got %0d want 2", dbg_state); end
    @(posedge clk); #1;
    tests++; if (cmd_err !== 1'b0) begin fails++; $display("FAIL held_err_clear: got %b want 0", cmd_err); end
    tests++; if (filas_raw !== ROW1_LOW) begin fails++; $display("FAIL held_err_key: got %h want %h", filas_raw, ROW1_LOW); end
    columnas = 4'b1101; #1;
    tests++; if (filas_raw !== ALL_HIGH) begin fails++; $display("FAIL held_err_newcol: got %h want %h", filas_raw, ALL_HIGH); end
    columnas = 4'b1011;
    tests++; if (key_down !== 1'b1 || press_count !== 8'd1) begin fails++; $display("FAIL held_err_status: key_down=%b count=%0d want 1/1", key_down, press_count); end
  endtask

  task automatic test_release();
    logic [3:0] exp_f;
    send_cmd(1'b0, 4'b0000);
    tests++; if (dbg_state !== 2'd3 || cmd_ready !== 1'b0) begin fails++; $display("FAIL rel_e0: state=%0d ready=%b want 3/0", dbg_state, cmd_ready); end
    tests++; if (filas_raw !== ROW1_LOW) begin fails++; $display("FAIL rel_filas_e0: got %h want %h", filas_raw, ROW1_LOW); end
    for (int k = 1; k <= BLEN; k++) begin
      @(posedge clk); #1;
      exp_f = (((k - 1) / BP) % 2 == 1) ? ROW1_LOW : ALL_HIGH;
      tests++; if (filas_raw !== exp_f) begin fails++; $display("FAIL rel_bounce_filas k=%0d: got %h want %h", k, filas_raw, exp_f); end
      tests++; if (key_down !== 1'b1 || cmd_ready !== 1'b0) begin fails++; $display("FAIL rel_bounce_flags k=%0d: key_down=%b ready=%b want 1/0", k, key_down, cmd_ready); end
    end
    @(posedge clk); #1;
    tests++; if (key_down !== 1'b0) begin fails++; $display("FAIL rel_key_down: got %b want 0", key_down); end
    tests++; if (filas_raw !== ALL_HIGH) begin fails++; $display("FAIL rel_filas: got %h want %h", filas_raw, ALL_HIGH); end
    tests++; if (cmd_ready !== 1'b1 || dbg_state !== 2'd0) begin fails++; $display("FAIL rel_state: ready=%b state=%0d want 1/0", cmd_ready, dbg_state); end
    tests++; if (press_count !== 8'd1) begin fails++; $display("FAIL rel_count: got %0d want 1", press_count); end
  endtask

  task automatic test_idle_release_err();
    send_cmd(1'b0, 4'b0000);
    tests++; if (cmd_err !== 1'b1) begin fails++; $display("FAIL idle_err_pulse: got %b want 1", cmd_err); end
    tests++; if (dbg_state !== 2'd0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL idle_err_state: state=%0d ready=%b want 0/1", dbg_state, cmd_ready); end
    @(posedge clk); #1;
    tests++; if (cmd_err !== 1'b0) begin fails++; $display("FAIL idle_err_clear: got %b want 0", cmd_err); end
    tests++; if (key_down !== 1'b0 || filas_raw !== ALL_HIGH) begin fails++; $display("FAIL idle_err_outputs: key_down=%b filas=%h want 0/f", key_down, filas_raw); end
  endtask

  task automatic test_reset_mid_bounce();
    int kr;
    logic [3:0] exp_f;
    kr = (BLEN >= 7) ? 7 : 1;
    send_cmd(1'b1, 4'b0110);
    repeat (kr) begin @(posedge clk); #1; end
    exp_f = (((kr - 1) / BP) % 2 == 0) ? ROW1_LOW : ALL_HIGH;
    tests++; if (filas_raw !== exp_f) begin fails++; $display("FAIL midrst_pre_filas: got %h want %h", filas_raw, exp_f); end
    tests++; if (dbg_state !== 2'd1 || press_count !== 8'd1) begin fails++; $display("FAIL midrst_pre_state: state=%0d count=%0d want 1/1", dbg_state, press_count); end
    reset = 1'b1; #1;
    tests++; if (filas_raw !== ALL_HIGH) begin fails++; $display("FAIL midrst_filas: got %h want %h", filas_raw, ALL_HIGH); end
    tests++; if (key_down !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL midrst_flags: key_down=%b ready=%b want 0/1", key_down, cmd_ready); end
    tests++; if (dbg_state !== 2'd0 || press_count !== 8'd0) begin fails++; $display("FAIL midrst_state: state=%0d count=%0d want 0/0", dbg_state, press_count); end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (BLEN + 2) begin @(posedge clk); #1; end
    tests++; if (key_down !== 1'b0 || press_count !== 8'd0 || filas_raw !== ALL_HIGH) begin fails++; $display("FAIL midrst_after: key_down=%b count=%0d filas=%h want 0/0/f", key_down, press_count, filas_raw); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) begin
      send_cmd(1'b1, i[3:0]);
      send_cmd(1'b0, 4'b0000);
      if (i == 0) begin
        tests++; if (press_count !== 8'd1) begin fails++; $display("FAIL wrap_first: got %0d want 1", press_count); end
      end
      if (i == 254) begin
        tests++; if (press_count !== 8'd255) begin fails++; $display("FAIL wrap_255: got %0d want 255", press_count); end
      end
    end
    wait_ready();
    tests++; if (press_count !== 8'd0) begin fails++; $display("FAIL wrap_zero: got %0d want 0", press_count); end
    tests++; if (key_down !== 1'b0 || dbg_state !== 2'd0) begin fails++; $display("FAIL wrap_idle: key_down=%b state=%0d want 0/0", key_down, dbg_state); end
  endtask

  // Sequence and report
  initial begin
    test_reset();
    test_press();
    test_columns();
    test_held_press_err();
    test_release();
    test_idle_release_err();
    test_reset_mid_bounce();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
